// File: rtl/cart_rom_mapper_if.sv
// CPU-side and ROM-side bus of the cartridge ROM mapper.
// The master drives CPU requests and memory responses; the mapper is the slave.
interface cart_rom_mapper_if;
  logic [2:0]  mapper;
  logic [3:0]  offset;
  logic [24:0] rom_size;
  logic        cs;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic        cpu_wait;
  logic [24:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack;
  logic [7:0]  mem_din;

  modport master (
    output mapper, offset, rom_size, cs, cpu_addr, cpu_din, cpu_rd, cpu_wr,
           mem_ack, mem_din,
    input  cpu_dout, cpu_wait, mem_addr, mem_rd
  );

  modport slave (
    input  mapper, offset, rom_size, cs, cpu_addr, cpu_din, cpu_rd, cpu_wr,
           mem_ack, mem_din,
    output cpu_dout, cpu_wait, mem_addr, mem_rd
  );
endinterface

// File: rtl/cart_rom_mapper.sv
// MSX-style cartridge ROM mapper: bank registers, CPU-to-ROM address
// translation with range check, and a two-state read request FSM.
module cart_rom_mapper (
  input  logic              i_clk,
  input  logic              i_reset,
  cart_rom_mapper_if.slave  bus
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0][7:0]   r_bank, w_bank_cur, w_bank_nxt;
  logic [2:0]        r_mapper_q;
  logic              r_fresh;
  logic [7:0]        r_cpu_dout, w_cpu_dout_nxt;
  logic              r_cpu_wait, w_cpu_wait_nxt;
  logic [24:0]       r_mem_addr, w_mem_addr_nxt;
  logic              r_mem_rd, w_mem_rd_nxt;

  logic              w_rd_req, w_wr_req, w_wr_hit, w_mapped, w_oor;
  logic [1:0]        w_wr_sel, w_win;
  logic [25:0]       w_sub;
  logic [24:0]       w_raw;

  function automatic logic [3:0][7:0] bank_defaults(input logic [2:0] m);
    case (m)
      3'd5, 3'd6: bank_defaults = {8'd0, 8'd0, 8'd0, 8'd0};
      default:    bank_defaults = {8'd3, 8'd2, 8'd1, 8'd0};
    endcase
  endfunction

  assign w_rd_req = bus.cs && bus.cpu_rd;
  assign w_wr_req = bus.cs && bus.cpu_wr;
  assign w_mapped = (bus.mapper >= 3'd3) && (bus.mapper <= 3'd6);
  assign w_win    = bus.cpu_addr[14:13] - 2'd2;

  // Until the first edge after reset the banks are taken straight from the
  // defaults of the current mapper, so no constant reset value is wrong.
  assign w_bank_cur = r_fresh ? bank_defaults(bus.mapper) : r_bank;

  // Write decode: which bank register a CPU write targets for this mapper.
  always_comb begin
    w_wr_hit = 1'b0;
    w_wr_sel = 2'd0;
    if (w_wr_req) begin
      case (bus.mapper)
        3'd3: begin
          w_wr_hit = (bus.cpu_addr[15:13] >= 3'b011) && (bus.cpu_addr[15:13] <= 3'b101);
          w_wr_sel = w_win;
        end
        3'd4: begin
          w_wr_hit = (bus.cpu_addr[15:14] == 2'b01 || bus.cpu_addr[15:14] == 2'b10) &&
                     (bus.cpu_addr[12:11] == 2'b10);
          w_wr_sel = w_win;
        end
        3'd5: begin
          w_wr_hit = (bus.cpu_addr[15:13] == 3'b011);
          w_wr_sel = bus.cpu_addr[12:11];
        end
        3'd6: begin
          w_wr_hit = (bus.cpu_addr[15:13] == 3'b011) && (bus.cpu_addr[11] == 1'b0);
          w_wr_sel = {bus.cpu_addr[12], 1'b0};
        end
        default: begin
          w_wr_hit = 1'b0;
          w_wr_sel = 2'd0;
        end
      endcase
    end else begin
      w_wr_hit = 1'b0;
      w_wr_sel = 2'd0;
    end
  end

  // Bank update: a mapper change reloads defaults, otherwise apply the write.
  always_comb begin
    w_bank_nxt = w_bank_cur;
    if (!r_fresh && (bus.mapper != r_mapper_q)) begin
      w_bank_nxt = bank_defaults(bus.mapper);
    end else if (w_wr_hit) begin
      w_bank_nxt[w_wr_sel] = bus.cpu_din;
    end else begin
      w_bank_nxt = w_bank_cur;
    end
  end

  // Raw ROM address and out-of-range flag; ASCII16 keeps bank A/B in slots 0/2.
  always_comb begin
    w_sub = {10'd0, bus.cpu_addr} - {10'd0, bus.offset, 12'd0};
    w_raw = 25'd0;
    w_oor = 1'b1;
    if (w_mapped) begin
      if (bus.mapper == 3'd6) begin
        w_raw = {3'd0, w_bank_cur[bus.cpu_addr[15] ? 2'd2 : 2'd0], bus.cpu_addr[13:0]};
      end else begin
        w_raw = {4'd0, w_bank_cur[w_win], bus.cpu_addr[12:0]};
      end
      w_oor = !(bus.cpu_addr[15:14] == 2'b01 || bus.cpu_addr[15:14] == 2'b10) ||
              (w_raw >= bus.rom_size);
    end else begin
      w_raw = w_sub[24:0];
      w_oor = w_sub[25] || (w_raw >= bus.rom_size);
    end
  end

  // State, bank and output registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_bank     <= {8'd3, 8'd2, 8'd1, 8'd0};
      r_fresh    <= 1'b1;
      r_mapper_q <= 3'd0;
      r_cpu_dout <= 8'hFF;
      r_cpu_wait <= 1'b0;
      r_mem_addr <= 25'd0;
      r_mem_rd   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bank     <= w_bank_nxt;
      r_fresh    <= 1'b0;
      r_mapper_q <= bus.mapper;
      r_cpu_dout <= w_cpu_dout_nxt;
      r_cpu_wait <= w_cpu_wait_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_mem_rd   <= w_mem_rd_nxt;
    end
  end

  // Next-state logic of the read FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rd_req && !w_oor) w_state_nxt = S_WAIT;
        else                    w_state_nxt = S_IDLE;
      end
      S_WAIT: begin
        if (bus.mem_ack) w_state_nxt = S_IDLE;
        else             w_state_nxt = S_WAIT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next output values; out-of-range reads answer 0xFF without touching memory.
  always_comb begin
    w_cpu_dout_nxt = r_cpu_dout;
    w_cpu_wait_nxt = r_cpu_wait;
    w_mem_addr_nxt = r_mem_addr;
    w_mem_rd_nxt   = r_mem_rd;
    case (r_state)
      S_IDLE: begin
        if (w_rd_req && w_oor) begin
          w_cpu_dout_nxt = 8'hFF;
        end else if (w_rd_req) begin
          w_mem_addr_nxt = w_raw;
          w_mem_rd_nxt   = 1'b1;
          w_cpu_wait_nxt = 1'b1;
        end else begin
          w_mem_rd_nxt   = 1'b0;
          w_cpu_wait_nxt = 1'b0;
        end
      end
      S_WAIT: begin
        if (bus.mem_ack) begin
          w_cpu_dout_nxt = bus.mem_din;
          w_mem_rd_nxt   = 1'b0;
          w_cpu_wait_nxt = 1'b0;
        end else begin
          w_mem_rd_nxt   = 1'b1;
          w_cpu_wait_nxt = 1'b1;
        end
      end
      default: begin
        w_mem_rd_nxt   = 1'b0;
        w_cpu_wait_nxt = 1'b0;
      end
    endcase
  end

  assign bus.cpu_dout = r_cpu_dout;
  assign bus.cpu_wait = r_cpu_wait;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_rd   = r_mem_rd;

endmodule
